// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage sitting in front of a byte-wide instruction memory.
// Walks four consecutive byte addresses, assembles the bytes into a 32-bit
// instruction, and offers it to decode over a valid/ready handshake. A
// redirect (salto) reloads the fetch address at any time.
//
// States
//   FETCH | collecting bytes at pc_fetch + cnt, one per cycle
//   VALID | instruccion/pc offered to decode, waiting for listo
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high
//   direccion   out  byte address to memory (pc_fetch + cnt)
//   dato_mem    in   byte read at direccion, same cycle
//   instruccion out  assembled instruction (registered)
//   pc          out  address of first byte of instruccion (registered)
//   valida      out  instruccion/pc valid for decode
//   listo       in   decode accepts when valida && listo
//   salto       in   redirect request
//   destino     in   redirect target, sampled when salto = 1
module fetch_unit #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter bit         BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [7:0]  direccion,
  input  logic [7:0]  dato_mem,
  output logic [31:0] instruccion,
  output logic [7:0]  pc,
  output logic        valida,
  input  logic        listo,
  input  logic        salto,
  input  logic [7:0]  destino
);

  typedef enum logic {FETCH, VALID} state_t;

  state_t      state, state_next;
  logic [7:0]  pc_fetch;
  logic [1:0]  cnt;
  logic [23:0] byte_buf;   // lane i lives in byte_buf[8*i +: 8]
  logic [31:0] assembled;

  // cnt wraps to 0 on entering VALID, so direccion stays at pc_fetch there.
  assign direccion = pc_fetch + {6'b0, cnt};
  assign valida    = (state == VALID);

  // The fourth byte comes straight from memory, not from the buffer.
  always_comb begin
    assembled = '0;
    if (BIG_ENDIAN)
      assembled = {byte_buf[7:0], byte_buf[15:8], byte_buf[23:16], dato_mem};
    else
      assembled = {dato_mem, byte_buf[23:16], byte_buf[15:8], byte_buf[7:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH: if (!salto && cnt == 2'd3) state_next = VALID;
      VALID: if (salto || listo)        state_next = FETCH;
      default:                          state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_fetch    <= RESET_PC;
      cnt         <= 2'd0;
      byte_buf    <= 24'h0;
      instruccion <= 32'h0;
      pc          <= 8'h00;
    end else if (salto) begin
      // Redirect wins; a handshake in the same cycle still completes because
      // decode sampled valida && listo, we just do not advance by 4.
      pc_fetch <= destino;
      cnt      <= 2'd0;
    end else begin
      case (state)
        FETCH: begin
          case (cnt)
            2'd0: byte_buf[7:0]   <= dato_mem;
            2'd1: byte_buf[15:8]  <= dato_mem;
            2'd2: byte_buf[23:16] <= dato_mem;
            default: begin
              instruccion <= assembled;
              pc          <= pc_fetch;
            end
          endcase
          cnt <= cnt + 2'd1;
        end
        VALID: begin
          if (listo) begin
            pc_fetch <= pc_fetch + 8'd4;
            cnt      <= 2'd0;
          end
        end
        default: cnt <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, listo, salto;
  logic [7:0]  destino;
  logic [7:0]  dir_be, dir_le, dato_be, dato_le, pc_be, pc_le;
  logic [31:0] ins_be, ins_le;
  logic        val_be, val_le;
  logic [7:0]  mem [256];

  assign dato_be = mem[dir_be];
  assign dato_le = mem[dir_le];

  fetch_unit #(.RESET_PC(8'h00), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(reset), .direccion(dir_be), .dato_mem(dato_be),
    .instruccion(ins_be), .pc(pc_be), .valida(val_be),
    .listo(listo), .salto(salto), .destino(destino));

  fetch_unit #(.RESET_PC(8'h00), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset), .direccion(dir_le), .dato_mem(dato_le),
    .instruccion(ins_le), .pc(pc_le), .valida(val_le),
    .listo(listo), .salto(salto), .destino(destino));

  int vectors = 0;
  int errors  = 0;

  // Reference model: where the next instruction starts, how many of its
  // bytes have been read, and what is currently being offered.
  logic [7:0]  m_start;
  int          m_got;
  bit          m_valid;
  logic [31:0] m_be, m_le;
  logic [7:0]  m_pc;

  logic [7:0]  cap_dir, cap_pc;
  logic [31:0] cap_ins;

  function automatic logic [31:0] word_be(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    return {mem[a], mem[a1], mem[a2], mem[a3]};
  endfunction

  function automatic logic [31:0] word_le(input logic [7:0] a);
    logic [7:0] a1, a2, a3;
    a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [7:0] e_dir;
    @(posedge clk);
    if (reset) begin
      m_start = 8'h00; m_got = 0; m_valid = 0; m_be = 32'h0; m_le = 32'h0; m_pc = 8'h00;
    end else if (salto) begin
      m_start = destino; m_got = 0; m_valid = 0;
    end else if (m_valid) begin
      if (listo) begin
        m_valid = 0; m_start = m_start + 8'd4; m_got = 0;
      end
    end else begin
      m_got++;
      if (m_got == 4) begin
        m_valid = 1;
        m_be = word_be(m_start);
        m_le = word_le(m_start);
        m_pc = m_start;
      end
    end
    @(negedge clk);
    e_dir = m_start + 8'(m_got);
    chk("valida_be", {31'h0, val_be}, {31'h0, m_valid});
    chk("valida_le", {31'h0, val_le}, {31'h0, m_valid});
    if (!m_valid) begin
      chk("dir_be", {24'h0, dir_be}, {24'h0, e_dir});
      chk("dir_le", {24'h0, dir_le}, {24'h0, e_dir});
    end
    chk("instr_be", ins_be, m_be);
    chk("instr_le", ins_le, m_le);
    chk("pc_be", {24'h0, pc_be}, {24'h0, m_pc});
    chk("pc_le", {24'h0, pc_le}, {24'h0, m_pc});
  endtask

  task automatic wait_valid(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (val_be) break;
      step();
    end
    chk("wait_valida", {31'h0, val_be}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h8C; mem[1] = 8'h11; mem[2] = 8'h00; mem[3] = 8'h04;
    m_start = 8'h00; m_got = 0; m_valid = 0; m_be = 32'h0; m_le = 32'h0; m_pc = 8'h00;
    reset = 1'b1; listo = 1'b0; salto = 1'b0; destino = 8'h00;

    // Reset state
    step(); step();
    chk("rst_dir", {24'h0, dir_be}, 32'h00);
    chk("rst_instr", ins_be, 32'h0);

    // First instruction after reset release, listo held high
    reset = 1'b0; listo = 1'b1;
    step(); step(); step(); step();
    chk("t1_valida", {31'h0, val_be}, 32'h1);
    chk("t1_instr_be", ins_be, 32'h8C110004);
    chk("t1_instr_le", ins_le, 32'h0400118C);
    chk("t1_pc", {24'h0, pc_be}, 32'h00);
    step();
    chk("t1_next_dir", {24'h0, dir_be}, 32'h04);

    // Backpressure
    listo = 1'b0;
    wait_valid(20);
    cap_dir = dir_be; cap_pc = pc_be; cap_ins = ins_be;
    repeat (6) step();
    chk("bp_valida", {31'h0, val_be}, 32'h1);
    chk("bp_dir_frozen", {24'h0, dir_be}, {24'h0, cap_dir});
    chk("bp_instr", ins_be, cap_ins);
    chk("bp_pc", {24'h0, pc_be}, {24'h0, cap_pc});
    listo = 1'b1;
    step();
    chk("bp_resume_dir", {24'h0, dir_be}, {24'h0, 8'(cap_pc + 8'd4)});

    // Redirect at cnt = 2
    step(); step();
    salto = 1'b1; destino = 8'h40;
    step();
    salto = 1'b0;
    chk("redir_dir", {24'h0, dir_be}, 32'h40);
    wait_valid(20);
    chk("redir_pc", {24'h0, pc_be}, 32'h40);

    // salto together with listo in VALID
    salto = 1'b1; destino = 8'h10;
    step();
    salto = 1'b0; listo = 1'b0;
    wait_valid(20);
    chk("sl_pc10", {24'h0, pc_be}, 32'h10);
    salto = 1'b1; listo = 1'b1; destino = 8'h80;
    step();
    salto = 1'b0; listo = 1'b0;
    chk("sl_dir", {24'h0, dir_be}, 32'h80);
    wait_valid(20);
    chk("sl_pc80", {24'h0, pc_be}, 32'h80);

    // Address wrap inside an instruction
    salto = 1'b1; destino = 8'hFE;
    step();
    salto = 1'b0;
    chk("wrap_dir0", {24'h0, dir_be}, 32'hFE);
    step(); chk("wrap_dir1", {24'h0, dir_be}, 32'hFF);
    step(); chk("wrap_dir2", {24'h0, dir_be}, 32'h00);
    step(); chk("wrap_dir3", {24'h0, dir_be}, 32'h01);
    step();
    chk("wrap_pc", {24'h0, pc_be}, 32'hFE);
    chk("wrap_instr", ins_be, {mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]});

    // pc_fetch + 4 wraps from FC to 00
    salto = 1'b1; destino = 8'hFC;
    step();
    salto = 1'b0;
    wait_valid(20);
    listo = 1'b1;
    step();
    listo = 1'b0;
    wait_valid(20);
    chk("wrap_next_pc", {24'h0, pc_be}, 32'h00);

    // Reset while cnt = 1
    listo = 1'b1; salto = 1'b1; destino = 8'h20;
    step();
    salto = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("midrst_valida", {31'h0, val_be}, 32'h0);
    chk("midrst_dir", {24'h0, dir_be}, 32'h00);
    reset = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      listo   = ($urandom_range(0, 2) != 0);
      salto   = ($urandom_range(0, 9) == 0);
      destino = 8'($urandom);
      reset   = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
